// File: rtl/om_req_serializer.sv
// Serializes one multi-lane OM request into single-lane fragments in ascending lane order.
// First fragment appears 1 cycle after accept; one fragment per cycle, no bubble between requests.
module om_req_serializer #(
  parameter int NUM_LANES  = 4,
  parameter int DIM_BITS   = 11,
  parameter int COLOR_BITS = 32,
  parameter int DEPTH_BITS = 24,
  parameter int UUID_BITS  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [UUID_BITS-1:0]             in_uuid,
  input  logic [NUM_LANES-1:0]             in_mask,
  input  logic [NUM_LANES*DIM_BITS-1:0]    in_pos_x,
  input  logic [NUM_LANES*DIM_BITS-1:0]    in_pos_y,
  input  logic [NUM_LANES*COLOR_BITS-1:0]  in_color,
  input  logic [NUM_LANES*DEPTH_BITS-1:0]  in_depth,
  input  logic [NUM_LANES-1:0]             in_face,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [UUID_BITS-1:0]             out_uuid,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] out_lane,
  output logic [DIM_BITS-1:0]              out_pos_x,
  output logic [DIM_BITS-1:0]              out_pos_y,
  output logic [COLOR_BITS-1:0]            out_color,
  output logic [DEPTH_BITS-1:0]            out_depth,
  output logic                             out_face,
  output logic                             out_last,
  output logic                             busy
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                          state_q, state_d;
  logic [NUM_LANES-1:0]            pending_q, pending_d;
  logic [NUM_LANES-1:0]            sel_oh;
  logic [LW-1:0]                   sel;
  logic                            out_hs;
  logic                            accept;

  logic [UUID_BITS-1:0]            uuid_q;
  logic [NUM_LANES*DIM_BITS-1:0]   pos_x_q;
  logic [NUM_LANES*DIM_BITS-1:0]   pos_y_q;
  logic [NUM_LANES*COLOR_BITS-1:0] color_q;
  logic [NUM_LANES*DEPTH_BITS-1:0] depth_q;
  logic [NUM_LANES-1:0]            face_q;

  // Lowest pending lane wins; scanning downward leaves the lowest set bit last.
  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel       = LW'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = out_valid && (pending_q == sel_oh);
  assign out_hs    = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (out_hs && out_last);
  assign accept    = in_valid && in_ready;

  assign out_uuid  = uuid_q;
  assign out_lane  = sel;
  assign out_pos_x = pos_x_q[sel*DIM_BITS +: DIM_BITS];
  assign out_pos_y = pos_y_q[sel*DIM_BITS +: DIM_BITS];
  assign out_color = color_q[sel*COLOR_BITS +: COLOR_BITS];
  assign out_depth = depth_q[sel*DEPTH_BITS +: DEPTH_BITS];
  assign out_face  = face_q[sel];

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (accept) begin
      // Covers both the idle load and the reload on the final-lane handshake.
      pending_d = in_mask;
      state_d   = (in_mask != '0) ? SEND : IDLE;
    end else if (out_hs) begin
      pending_d = pending_q & ~sel_oh;
      if (out_last) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      uuid_q  <= in_uuid;
      pos_x_q <= in_pos_x;
      pos_y_q <= in_pos_y;
      color_q <= in_color;
      depth_q <= in_depth;
      face_q  <= in_face;
    end
  end

endmodule

// File: tb/tb_om_req_serializer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a fragment-queue model.
module tb_om_req_serializer;
  localparam int NL = 4;
  localparam int DW = 11;
  localparam int CW = 32;
  localparam int ZW = 24;
  localparam int UW = 1;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [UW-1:0]     in_uuid;
  logic [NL-1:0]     in_mask;
  logic [NL*DW-1:0]  in_pos_x, in_pos_y;
  logic [NL*CW-1:0]  in_color;
  logic [NL*ZW-1:0]  in_depth;
  logic [NL-1:0]     in_face;
  logic              out_valid, out_ready;
  logic [UW-1:0]     out_uuid;
  logic [LW-1:0]     out_lane;
  logic [DW-1:0]     out_pos_x, out_pos_y;
  logic [CW-1:0]     out_color;
  logic [ZW-1:0]     out_depth;
  logic              out_face, out_last, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [UW-1:0] uuid;
    logic [LW-1:0] lane;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [CW-1:0] color;
    logic [ZW-1:0] depth;
    logic          face;
  } frag_t;

  frag_t exp_q[$];

  om_req_serializer #(
    .NUM_LANES(NL), .DIM_BITS(DW), .COLOR_BITS(CW), .DEPTH_BITS(ZW), .UUID_BITS(UW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_mask(in_mask),
    .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_color(in_color), .in_depth(in_depth),
    .in_face(in_face),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_lane(out_lane),
    .out_pos_x(out_pos_x), .out_pos_y(out_pos_y), .out_color(out_color), .out_depth(out_depth),
    .out_face(out_face), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted request expands into its set lanes, lowest first;
  // the head of the queue is what must be on the output.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      int  sz;
      bit  rdy;
      sz  = exp_q.size();
      rdy = (sz == 0) || (out_ready && sz == 1);
      if (sz > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) begin
        for (int i = 0; i < NL; i++) begin
          if (in_mask[i]) begin
            frag_t f;
            f.uuid  = in_uuid;
            f.lane  = LW'(i);
            f.x     = in_pos_x[i*DW +: DW];
            f.y     = in_pos_y[i*DW +: DW];
            f.color = in_color[i*CW +: CW];
            f.depth = in_depth[i*ZW +: ZW];
            f.face  = in_face[i];
            exp_q.push_back(f);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      int sz;
      sz = exp_q.size();
      chk("m_out_valid", 64'(out_valid), 64'(sz > 0));
      chk("m_busy", 64'(busy), 64'(sz > 0));
      chk("m_in_ready", 64'(in_ready), 64'((sz == 0) || (out_ready && sz == 1)));
      if (sz > 0) begin
        chk("m_uuid", 64'(out_uuid), 64'(exp_q[0].uuid));
        chk("m_lane", 64'(out_lane), 64'(exp_q[0].lane));
        chk("m_pos_x", 64'(out_pos_x), 64'(exp_q[0].x));
        chk("m_pos_y", 64'(out_pos_y), 64'(exp_q[0].y));
        chk("m_color", 64'(out_color), 64'(exp_q[0].color));
        chk("m_depth", 64'(out_depth), 64'(exp_q[0].depth));
        chk("m_face", 64'(out_face), 64'(exp_q[0].face));
        chk("m_last", 64'(out_last), 64'(sz == 1));
      end
    end
  end

  task automatic set_req(input logic [UW-1:0] uuid, input logic [NL-1:0] mask);
    in_valid = 1'b1;
    in_uuid  = uuid;
    in_mask  = mask;
    for (int i = 0; i < NL; i++) begin
      in_pos_x[i*DW +: DW] = DW'(100 + i);
      in_pos_y[i*DW +: DW] = DW'(200 + i);
      in_color[i*CW +: CW] = 32'hC0DE_0000 + CW'(i);
      in_depth[i*ZW +: ZW] = 24'hD0_0000 + ZW'(i);
      in_face[i]           = (i % 2) == 1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_uuid   = '0;
    in_mask   = '0;
    in_pos_x  = '0;
    in_pos_y  = '0;
    in_color  = '0;
    in_depth  = '0;
    in_face   = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Full mask, no stall
    @(posedge clk); #1 set_req(1'b1, 4'b1111);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_valid", 64'(out_valid), 64'd1);
      chk("full_lane", 64'(out_lane), 64'(k));
      chk("full_last", 64'(out_last), 64'(k == 3));
      chk("full_x", 64'(out_pos_x), 64'(100 + k));
      chk("full_color", 64'(out_color), 64'h0000_0000_C0DE_0000 + 64'(k));
    end
    @(negedge clk) chk("full_done", 64'(out_valid), 64'd0);

    // Sparse mask with a 3-cycle stall on the first fragment
    @(posedge clk); #1 set_req(1'b0, 4'b1010); out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_lane", 64'(out_lane), 64'd1);
      chk("stall_y", 64'(out_pos_y), 64'd201);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_last", 64'(out_last), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("sparse_lane3", 64'(out_lane), 64'd3);
    chk("sparse_last", 64'(out_last), 64'd1);
    chk("sparse_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) chk("sparse_done", 64'(out_valid), 64'd0);

    // Back-to-back: B is accepted on A's final handshake
    @(posedge clk); #1 set_req(1'b0, 4'b0001);
    @(posedge clk); #1 set_req(1'b1, 4'b1100);
    @(negedge clk);
    chk("b2b_a_lane", 64'(out_lane), 64'd0);
    chk("b2b_a_uuid", 64'(out_uuid), 64'd0);
    chk("b2b_a_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_b_valid", 64'(out_valid), 64'd1);
    chk("b2b_b_lane2", 64'(out_lane), 64'd2);
    chk("b2b_b_uuid", 64'(out_uuid), 64'd1);
    @(negedge clk);
    chk("b2b_b_lane3", 64'(out_lane), 64'd3);
    chk("b2b_b_last", 64'(out_last), 64'd1);

    // Zero mask is consumed silently, then a normal request follows
    @(posedge clk); #1 set_req(1'b1, 4'b0000);
    @(posedge clk); #1 set_req(1'b1, 4'b0100);
    @(negedge clk);
    chk("zero_valid", 64'(out_valid), 64'd0);
    chk("zero_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("after_zero_lane", 64'(out_lane), 64'd2);

    // Reset after lane 1 handshake drops lanes 2 and 3
    @(posedge clk); #1 set_req(1'b0, 4'b1111);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("rstmid_lane0", 64'(out_lane), 64'd0);
    @(negedge clk) chk("rstmid_lane1", 64'(out_lane), 64'd1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 set_req(1'b1, 4'b1110);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) chk("post_rst_lane", 64'(out_lane), 64'd1);
    repeat (3) @(posedge clk);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      in_uuid   = UW'($urandom);
      case ($urandom_range(0, 3))
        0:       in_mask = '0;
        1:       in_mask = '1;
        default: in_mask = NL'($urandom);
      endcase
      in_pos_x = (NL*DW)'({$urandom, $urandom});
      in_pos_y = (NL*DW)'({$urandom, $urandom});
      in_color = {$urandom, $urandom, $urandom, $urandom};
      in_depth = {$urandom, $urandom, $urandom};
      in_face  = NL'($urandom);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) chk("drain_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
